dft_unload_datapath: RTL and testbench
======================================

# dft_unload_datapath

Parametrised scan-unload datapath for the DFT path. It samples NCH parallel scan-chain outputs while driving their shift enable and packs the bits into WORD_W-bit words. Words are buffered in a DEPTH-entry FIFO and presented on a valid/ready output port. When the FIFO is full, shifting stalls instead of losing data. It is the multi-chain, flow-controlled successor to the single-chain SIPO buffer plus output register.

## Interface
- NCH, 4, number of scan chains sampled per shift cycle; WORD_W % NCH == 0.
- WORD_W, 32, output word width.
- DEPTH, 8, FIFO depth in words; power of 2, at least 2.
- LEN_W, 16, width of the chain-length field.
- clk  in  1  single clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins an unload; ignored while busy.
- abort  in  1  synchronous abort; returns the block to IDLE and empties the FIFO.
- chain_len  in  LEN_W  shift count per chain, sampled on start.
- ch_mask  in  NCH  per-chain enable, sampled on start; a masked chain contributes 0.
- scan_in  in  NCH  serial scan-out bits, bit i from chain i.
- scan_en  out  1  shift enable to the chains.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of an unload.
- word_cnt  out  LEN_W  words pushed during the current or last unload.
- out_data  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts out_data.

## Operation
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE → SHIFT on start when chain_len != 0.
  - On that transition: latch chain_len and ch_mask; clear shift_cnt, bit_cnt and word_cnt.
- IDLE → DONE on start when chain_len == 0. No words are pushed.
- SHIFT drives scan_en = !fifo_full.
  - Each cycle with scan_en high samples scan_in & mask into accumulator bits [bit_cnt*NCH +: NCH]. Packing is LSB-first, so the first shift lands in bits [NCH-1:0].
  - After WORD_W/NCH samples, the word is pushed and bit_cnt wraps to 0.
  - The push cannot be lost: fifo_full was low when scan_en was asserted.
- SHIFT → FLUSH when shift_cnt reaches chain_len.
- FLUSH handles a trailing partial word (bit_cnt != 0).
  - Zero-pad the upper bits and push the word once !fifo_full, then go to DONE.
  - If bit_cnt == 0, go to DONE immediately.
- DONE pulses done for one cycle, then → IDLE.
- Pop happens when out_valid && out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - The FIFO keeps draining in IDLE, so a new unload may start before the FIFO is empty.
- word_cnt increments on each push and holds its value after done until the next start.
- abort in any state → IDLE.
  - Pointers are cleared and out_valid drops next cycle.
  - No done pulse; word_cnt holds.
  - abort has priority over start, push and pop in the same cycle.
- Asynchronous reset forces:
  - state = IDLE;
  - all counters and FIFO pointers = 0;
  - scan_en = 0, busy = 0, done = 0, out_valid = 0, word_cnt = 0, out_data = 0.
- Reset mid-unload discards all partial and buffered data.

## Timing
- start sampled at edge T → scan_en high during cycle T+1, provided the FIFO is not full.
- scan_in is sampled at the rising edge that ends a scan_en-high cycle.
- A word completed at edge E → out_valid high and out_data valid in cycle E+1. The FIFO is first-word-fall-through with a registered head.
- Stall: scan_en falls in the same cycle fifo_full rises (combinational from registered count). It reasserts the cycle after a pop frees an entry.
- Unload duration with no backpressure:
  - chain_len scan_en cycles;
  - plus 1 FLUSH cycle;
  - plus 1 DONE cycle.
- busy is high from T+1 through the DONE cycle inclusive.

## Test plan
- NCH=4, WORD_W=32, chain_len=16, mask=4'hF, scan_in = shift index (0..F), out_ready=1 → words 0x76543210 then 0xFEDCBA98; word_cnt=2; done 18 cycles after start.
- Same setup with chain_len=10 → words 0x76543210, 0x00000098; word_cnt=2.
- ch_mask=4'b0101, scan_in=4'hF, chain_len=8 → single word 0x55555555.
- DEPTH=4, out_ready=0, chain_len=64:
  - Phase 1 → scan_en drops after 32 shifts with 4 words queued and busy held.
  - Phase 2: raise out_ready → shifting resumes; 8 words total, delivered in order; done once.
- chain_len=0 → done one cycle after start; no out_valid; word_cnt=0.
- Interruption mid-unload, two runs:
  - Run A: abort after 5 shifts of chain_len=16 → IDLE next cycle, out_valid=0, no done.
  - Run B: pulse reset_n low at the same point → IDLE immediately, all outputs 0.
  - Follow each run with a clean 16-shift unload → expect exact data as in the first scenario.

Source files
------------

// File: rtl/dft_unload_datapath.sv
// Scan-unload datapath: samples NCH chains per shift, packs LSB-first into WORD_W words, queues them.
// Latency: word completed at edge E is on out_data/out_valid in cycle E+1; done 2 cycles after the last shift.
// Backpressure: scan_en drops while the FIFO is full and reasserts the cycle after a pop frees an entry.

// Generic FIFO: first-word-fall-through, head read straight from the storage registers.
// Latency: a push at edge E is visible on out_data in cycle E+1.
// Backpressure: pushes are dropped when full (callers must check full); clr wins over push and pop.
module dft_unload_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign do_push   = push && !full && !clr;
  assign do_pop    = pop && out_valid && !clr;
  // An empty FIFO presents zero so stale storage never shows on the bus.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking; clear empties the queue without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end
endmodule

module dft_unload_datapath #(
  parameter int NCH    = 4,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [NCH-1:0]    scan_in,
  output logic              scan_en,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_cnt,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int WPW = WORD_W / NCH;
  localparam int BW  = (WPW > 1) ? $clog2(WPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [NCH-1:0]    mask_q;
  logic [LEN_W-1:0]  shift_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] word_nxt;
  logic [WORD_W-1:0] push_dat;
  logic              push_vld;
  logic              fifo_full;
  logic              last_bit;
  logic              last_shift;

  assign last_bit   = (bit_cnt == BW'(WPW - 1));
  assign last_shift = ((shift_cnt + LEN_W'(1)) == len_q);
  // Stall is combinational from the registered occupancy, so a shift never outruns the FIFO.
  assign scan_en    = (state == S_SHIFT) && !fifo_full;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Merge the current sample into the accumulator and decide whether a word leaves this cycle.
  always_comb begin
    word_nxt = acc;
    word_nxt[bit_cnt*NCH +: NCH] = scan_in & mask_q;
    push_vld = 1'b0;
    push_dat = word_nxt;
    if (!abort) begin
      if (state == S_SHIFT && scan_en && last_bit) begin
        push_vld = 1'b1;
        push_dat = word_nxt;
      end else if (state == S_FLUSH && bit_cnt != '0 && !fifo_full) begin
        // Upper bits of a partial word are already zero because acc is cleared per word.
        push_vld = 1'b1;
        push_dat = acc;
      end
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (chain_len != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (scan_en && last_shift) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (bit_cnt == '0 || !fifo_full) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Shift/pack counters, accumulator and word count; abort freezes them so word_cnt holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      mask_q    <= '0;
      shift_cnt <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      word_cnt  <= '0;
    end else if (!abort) begin
      if (state == S_IDLE && start) begin
        len_q     <= chain_len;
        mask_q    <= ch_mask;
        shift_cnt <= '0;
        bit_cnt   <= '0;
        acc       <= '0;
        word_cnt  <= '0;
      end else if (state == S_SHIFT && scan_en) begin
        shift_cnt <= shift_cnt + LEN_W'(1);
        if (last_bit) begin
          bit_cnt <= '0;
          acc     <= '0;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
          acc     <= word_nxt;
        end
      end else if (state == S_FLUSH && push_vld) begin
        bit_cnt <= '0;
        acc     <= '0;
      end
      if (push_vld) word_cnt <= word_cnt + LEN_W'(1);
    end
  end

  dft_unload_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (abort),
    .push      (push_vld),
    .push_data (push_dat),
    .pop       (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_dft_unload_datapath.sv
// Bench for dft_unload_datapath: directed unload vectors plus stall, abort and reset sequences.
// Latency: checks done timing relative to the start edge and first-word visibility.
// Backpressure: exercised with a 4-deep FIFO and out_ready held low.
module tb_dft_unload_datapath;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] chain_len;
  logic [3:0]  ch_mask;
  logic [3:0]  scan_in;
  logic        scan_en;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          sidx;
  int          mode;
  int          done_cnt;
  int          done_cyc;
  logic [31:0] got_q [$];

  typedef struct {
    logic [15:0] len;
    logic [3:0]  mask;
    int          mode;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          dcyc;
  } vec_t;

  vec_t vecs [4];

  dft_unload_datapath #(
    .NCH    (4),
    .WORD_W (32),
    .DEPTH  (4),
    .LEN_W  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .chain_len (chain_len),
    .ch_mask   (ch_mask),
    .scan_in   (scan_in),
    .scan_en   (scan_en),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic        en;
    logic [31:0] t;
    t       = sidx;
    scan_in = (mode == 0) ? t[3:0] : 4'hF;
    en      = scan_en;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    if (en) sidx++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic [3:0] mask);
    chain_len = len;
    ch_mask   = mask;
    start     = 1'b1;
    got_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    sidx      = 0;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int maxc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", maxc);
    end
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    mode = v.mode;
    pulse_start(v.len, v.mask);
    run_to_done(300);
    check({tag, "_nwords"}, got_q.size(), v.nw);
    for (int k = 0; k < v.nw; k++)
      check($sformatf("%s_word%0d", tag, k), (k < got_q.size()) ? got_q[k] : 32'hDEADBEEF,
            (k == 0) ? v.w0 : v.w1);
    check({tag, "_word_cnt"}, word_cnt, v.nw);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, v.dcyc);
  endtask

  task automatic apply_abort();
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    vecs[0] = '{len: 16'd16, mask: 4'hF, mode: 0, nw: 2, w0: 32'h76543210, w1: 32'hFEDCBA98, dcyc: 18};
    vecs[1] = '{len: 16'd10, mask: 4'hF, mode: 0, nw: 2, w0: 32'h76543210, w1: 32'h00000098, dcyc: 12};
    vecs[2] = '{len: 16'd8,  mask: 4'h5, mode: 1, nw: 1, w0: 32'h55555555, w1: 32'h0,        dcyc: 10};
    vecs[3] = '{len: 16'd0,  mask: 4'hF, mode: 0, nw: 0, w0: 32'h0,        w1: 32'h0,        dcyc: 1};

    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    chain_len = '0;
    ch_mask   = '0;
    scan_in   = '0;
    out_ready = 1'b1;
    mode      = 0;
    sidx      = 0;
    cyc       = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    repeat (2) @(negedge clk);
    check("rst_scan_en", scan_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: 4-deep FIFO fills after 32 shifts, then drains and the unload completes.
    out_ready = 1'b0;
    mode      = 0;
    pulse_start(16'd64, 4'hF);
    begin
      int n;
      n = 0;
      while (n < 100 && scan_en) begin
        tick();
        n++;
      end
    end
    check("stall_cycle", cyc, 33);
    check("stall_shifts", sidx, 32);
    check("stall_busy", busy, 1);
    check("stall_out_valid", out_valid, 1);
    check("stall_head", out_data, 32'h76543210);
    repeat (4) tick();
    check("stall_held_shifts", sidx, 32);
    check("stall_held_scan_en", scan_en, 0);
    out_ready = 1'b1;
    run_to_done(300);
    check("bp_nwords", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("bp_word%0d", k), (k < got_q.size()) ? got_q[k] : 32'hDEADBEEF,
            (k % 2 == 0) ? 32'h76543210 : 32'hFEDCBA98);
    check("bp_word_cnt", word_cnt, 8);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_total_shifts", sidx, 64);

    // Abort with a word queued: FIFO empties, word_cnt holds, no done.
    out_ready = 1'b0;
    pulse_start(16'd16, 4'hF);
    repeat (9) tick();
    check("abq_out_valid_before", out_valid, 1);
    check("abq_word_cnt_before", word_cnt, 1);
    apply_abort();
    check("abq_out_valid", out_valid, 0);
    check("abq_busy", busy, 0);
    check("abq_scan_en", scan_en, 0);
    check("abq_word_cnt_hold", word_cnt, 1);
    out_ready = 1'b1;
    repeat (10) tick();
    check("abq_no_pop", got_q.size(), 0);
    check("abq_no_done", done_cnt, 0);

    // Run A: abort after 5 shifts, then a clean unload.
    pulse_start(16'd16, 4'hF);
    repeat (5) tick();
    check("abA_shifts", sidx, 5);
    apply_abort();
    check("abA_busy", busy, 0);
    check("abA_out_valid", out_valid, 0);
    check("abA_done", done, 0);
    repeat (5) tick();
    check("abA_no_done", done_cnt, 0);
    run_vec(vecs[0], "abA_clean");

    // Run B: reset pulse after 5 shifts, then a clean unload.
    pulse_start(16'd16, 4'hF);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("rsB_scan_en", scan_en, 0);
    check("rsB_busy", busy, 0);
    check("rsB_done", done, 0);
    check("rsB_out_valid", out_valid, 0);
    check("rsB_word_cnt", word_cnt, 0);
    check("rsB_out_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "rsB_clean");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
